// File: rtl/lsu.sv
// lsu -- memory-access stage between ALU control and register-file writeback.
//   Loads and stores go out over a req/ack data-memory port. All other results
//   pass straight through. The writeback value leaves on a valid/ready handshake.
// Parameters:
//   TIMEOUT_CYCLES  REQ cycles allowed without mem_ack before a timeout fault (1..65535)
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   in_valid/in_ready         upstream handshake; ready only while idle
//   op, func3                 opcode and access width/sign selector
//   alu_result, store_data    effective address (or pass-through result) and rs2
//   out_valid/out_ready       downstream handshake
//   out_data, out_wb          writeback value and register-write enable
//   out_fault                 0 none, 1 misaligned, 2 illegal func3, 3 memory timeout
//   mem_req/mem_we/mem_addr   data-memory request, write flag, word address
//   mem_be/mem_wdata          byte enables, lane-replicated store data
//   mem_ack/mem_rdata         memory completion and load word
module lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  op,
  input  logic [2:0]  func3,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_wb,
  output logic [1:0]  out_fault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [31:0] out_data_q, out_data_d;
  logic        out_wb_q, out_wb_d;
  logic [1:0]  out_fault_q, out_fault_d;
  logic [15:0] cnt_q, cnt_d;
  logic        ld_q, ld_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  lane_q, lane_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;

  // Decode of the instruction currently offered upstream.
  logic        is_load, is_store, is_mem, f3_bad, misal, timeout_hit;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;

  assign is_load     = (op == 7'b0000011);
  assign is_store    = (op == 7'b0100011);
  assign is_mem      = is_load | is_store;
  assign f3_bad      = is_load ? ((func3 == 3'b011) || (func3[2:1] == 2'b11))
                               : (func3[2] || (func3 == 3'b011));
  assign misal       = ((func3[1:0] == 2'b01) && alu_result[0]) ||
                       ((func3[1:0] == 2'b10) && (alu_result[1:0] != 2'b00));
  assign timeout_hit = (cnt_q == 16'(TIMEOUT_CYCLES - 1));

  always_comb begin
    be_new    = 4'b1111;
    wdata_new = store_data;
    case (func3[1:0])
      2'b00: begin
        be_new    = 4'b0001 << alu_result[1:0];
        wdata_new = {4{store_data[7:0]}};
      end
      2'b01: begin
        be_new    = 4'b0011 << {alu_result[1], 1'b0};
        wdata_new = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lane extraction from the latched width and address offset.
  logic [31:0] sh_b, sh_h, ld_val;
  assign sh_b = mem_rdata >> {lane_q, 3'b000};
  assign sh_h = mem_rdata >> {lane_q[1], 4'b0000};

  always_comb begin
    case (f3_q)
      3'b000:  ld_val = {{24{sh_b[7]}}, sh_b[7:0]};
      3'b100:  ld_val = {24'h0, sh_b[7:0]};
      3'b001:  ld_val = {{16{sh_h[15]}}, sh_h[15:0]};
      3'b101:  ld_val = {16'h0, sh_h[15:0]};
      default: ld_val = mem_rdata;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (in_valid) state_d = (is_mem && !f3_bad && !misal) ? S_REQ : S_RESP;
      S_REQ:  if (mem_ack || timeout_hit) state_d = S_RESP;
      S_RESP: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values.
  always_comb begin
    out_data_d  = out_data_q;
    out_wb_d    = out_wb_q;
    out_fault_d = out_fault_q;
    cnt_d       = cnt_q;
    ld_d        = ld_q;
    f3_d        = f3_q;
    lane_d      = lane_q;
    we_d        = we_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    case (state_q)
      S_IDLE: if (in_valid) begin
        out_data_d  = '0;
        out_wb_d    = 1'b0;
        out_fault_d = 2'd0;
        if (!is_mem) begin
          out_data_d = alu_result;
          out_wb_d   = 1'b1;
        end else if (f3_bad) begin
          out_fault_d = 2'd2;
        end else if (misal) begin
          out_fault_d = 2'd1;
        end else begin
          cnt_d   = '0;
          ld_d    = is_load;
          f3_d    = func3;
          lane_d  = alu_result[1:0];
          we_d    = is_store;
          addr_d  = {alu_result[31:2], 2'b00};
          be_d    = be_new;
          wdata_d = wdata_new;
        end
      end
      S_REQ: begin
        // An ack arriving in the timeout cycle completes normally.
        if (mem_ack) begin
          out_data_d = ld_q ? ld_val : '0;
          out_wb_d   = ld_q;
        end else if (timeout_hit) begin
          out_fault_d = 2'd3;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q  <= '0;
      out_wb_q    <= 1'b0;
      out_fault_q <= 2'd0;
      cnt_q       <= '0;
      ld_q        <= 1'b0;
      f3_q        <= '0;
      lane_q      <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_wb_q    <= out_wb_d;
      out_fault_q <= out_fault_d;
      cnt_q       <= cnt_d;
      ld_q        <= ld_d;
      f3_q        <= f3_d;
      lane_q      <= lane_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
    end
  end

  // Outputs.
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_RESP);
    mem_req   = (state_q == S_REQ);
    mem_we    = (state_q == S_REQ) && we_q;
    out_fault = (state_q == S_RESP) ? out_fault_q : 2'd0;
    out_data  = out_data_q;
    out_wb    = out_wb_q;
    mem_addr  = addr_q;
    mem_be    = be_q;
    mem_wdata = wdata_q;
  end

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  op = '0;
  logic [2:0]  func3 = '0;
  logic [31:0] alu_result = '0;
  logic [31:0] store_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic        out_wb;
  logic [1:0]  out_fault;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .func3(func3), .alu_result(alu_result), .store_data(store_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_wb(out_wb), .out_fault(out_fault),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        wb;
    logic [1:0]  f;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ADDI  = 7'b0010011;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_out(input logic [31:0] d, input logic wb, input logic [1:0] f);
    exp_t e;
    e.d = d; e.wb = wb; e.f = f;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Offer one instruction; returns #1 after the accepting edge.
  task automatic issue(input logic [6:0] o, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd);
    int n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    if (!in_ready) chk("issue_wait_ready", 32'(in_ready), 32'd1);
    op = o; func3 = f3; alu_result = a; store_data = sd; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Scoreboard monitor: one pop per completed output handshake.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_data", out_data, e.d);
        chk("out_wb", 32'(out_wb), 32'(e.wb));
        chk("out_fault", 32'(out_fault), 32'(e.f));
      end
    end
  end

  initial begin
    int n;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_out_wb", 32'(out_wb), 32'd0);
    chk("rst_out_fault", 32'(out_fault), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    #12 rst = 1'b0;
    tick();

    // Pass-through: result next cycle, no memory access.
    expect_out(32'h0000_1234, 1'b1, 2'd0);
    issue(OP_ADDI, 3'b000, 32'h0000_1234, 32'h0);
    chk("addi_valid_n1", 32'(out_valid), 32'd1);
    chk("addi_no_req", 32'(mem_req), 32'd0);

    // LB from byte lane 3, ack in first REQ cycle.
    expect_out(32'hFFFF_FF80, 1'b1, 2'd0);
    issue(OP_LOAD, 3'b000, 32'h0000_0103, 32'h0);
    chk("lb_req", 32'(mem_req), 32'd1);
    chk("lb_addr", mem_addr, 32'h0000_0100);
    chk("lb_be", 32'(mem_be), 32'b1000);
    chk("lb_we", 32'(mem_we), 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h80FF_0000;
    tick();
    mem_ack = 1'b0;
    chk("lb_valid", 32'(out_valid), 32'd1);

    // SH upper half, ack in second REQ cycle; request fields held.
    expect_out(32'h0, 1'b0, 2'd0);
    issue(OP_STORE, 3'b001, 32'h0000_0202, 32'hABCD_1234);
    chk("sh_be", 32'(mem_be), 32'b1100);
    chk("sh_wdata", mem_wdata, 32'h1234_1234);
    chk("sh_we", 32'(mem_we), 32'd1);
    chk("sh_addr", mem_addr, 32'h0000_0200);
    tick();
    chk("sh_req_held", 32'(mem_req), 32'd1);
    chk("sh_wdata_held", mem_wdata, 32'h1234_1234);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;

    // SB lane 1 and SW.
    expect_out(32'h0, 1'b0, 2'd0);
    issue(OP_STORE, 3'b000, 32'h0000_0001, 32'h0000_0055);
    chk("sb_be", 32'(mem_be), 32'b0010);
    chk("sb_wdata", mem_wdata, 32'h5555_5555);
    mem_ack = 1'b1; tick(); mem_ack = 1'b0;
    expect_out(32'h0, 1'b0, 2'd0);
    issue(OP_STORE, 3'b010, 32'h0000_0300, 32'hDEAD_BEEF);
    chk("sw_be", 32'(mem_be), 32'b1111);
    chk("sw_wdata", mem_wdata, 32'hDEAD_BEEF);
    mem_ack = 1'b1; tick(); mem_ack = 1'b0;

    // LH / LHU upper half, LBU lane 1.
    expect_out(32'hFFFF_8001, 1'b1, 2'd0);
    issue(OP_LOAD, 3'b001, 32'h0000_0102, 32'h0);
    chk("lh_be", 32'(mem_be), 32'b1100);
    mem_ack = 1'b1; mem_rdata = 32'h8001_7F00; tick(); mem_ack = 1'b0;
    expect_out(32'h0000_8001, 1'b1, 2'd0);
    issue(OP_LOAD, 3'b101, 32'h0000_0102, 32'h0);
    mem_ack = 1'b1; mem_rdata = 32'h8001_7F00; tick(); mem_ack = 1'b0;
    expect_out(32'h0000_009A, 1'b1, 2'd0);
    issue(OP_LOAD, 3'b100, 32'h0000_0101, 32'h0);
    mem_ack = 1'b1; mem_rdata = 32'h0000_9A00; tick(); mem_ack = 1'b0;

    // Early faults: misaligned LW, illegal func3 beats misalignment.
    expect_out(32'h0, 1'b0, 2'd1);
    issue(OP_LOAD, 3'b010, 32'h0000_0101, 32'h0);
    chk("misal_no_req", 32'(mem_req), 32'd0);
    chk("misal_valid", 32'(out_valid), 32'd1);
    expect_out(32'h0, 1'b0, 2'd2);
    issue(OP_LOAD, 3'b011, 32'h0000_0101, 32'h0);
    chk("illf3_no_req", 32'(mem_req), 32'd0);
    expect_out(32'h0, 1'b0, 2'd2);
    issue(OP_STORE, 3'b100, 32'h0000_0100, 32'h0);

    // Timeout with TIMEOUT_CYCLES=4: four REQ cycles, then fault 3.
    expect_out(32'h0, 1'b0, 2'd3);
    issue(OP_LOAD, 3'b010, 32'h0000_0400, 32'h0);
    n = 0;
    while (mem_req && n < 20) begin n++; tick(); end
    chk("timeout_req_cycles", 32'(n), 32'd4);
    chk("timeout_valid", 32'(out_valid), 32'd1);

    // Ack in the fourth REQ cycle completes normally.
    expect_out(32'h1122_3344, 1'b1, 2'd0);
    issue(OP_LOAD, 3'b010, 32'h0000_0404, 32'h0);
    tick(); tick(); tick();
    mem_ack = 1'b1; mem_rdata = 32'h1122_3344; tick(); mem_ack = 1'b0;
    chk("late_ack_valid", 32'(out_valid), 32'd1);
    tick();

    // Ack while idle is ignored.
    mem_ack = 1'b1; tick(); mem_ack = 1'b0;
    chk("idle_ack_no_valid", 32'(out_valid), 32'd0);
    chk("idle_ack_ready", 32'(in_ready), 32'd1);

    // Backpressure holds the result; new input is not accepted meanwhile.
    out_ready = 1'b0;
    expect_out(32'h0000_CAFE, 1'b1, 2'd0);
    issue(OP_ADDI, 3'b000, 32'h0000_CAFE, 32'h0);
    op = OP_ADDI; alu_result = 32'h0000_9999; in_valid = 1'b1;
    tick(); tick(); tick();
    chk("hold_valid", 32'(out_valid), 32'd1);
    chk("hold_data", out_data, 32'h0000_CAFE);
    chk("hold_not_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();

    // Reset during REQ drops the request at once; late ack ignored.
    issue(OP_LOAD, 3'b010, 32'h0000_0500, 32'h0);
    chk("rstreq_req_before", 32'(mem_req), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rstreq_req_drop", 32'(mem_req), 32'd0);
    chk("rstreq_ready", 32'(in_ready), 32'd1);
    #1 rst = 1'b0;
    tick();
    mem_ack = 1'b1; tick(); mem_ack = 1'b0;
    tick();
    chk("rstreq_no_valid", 32'(out_valid), 32'd0);

    tick(); tick();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
